// File: rtl/subtree_arb_pkg.sv
// Shared definitions for the subtree round-robin arbiter: FSM state
// encoding, default sizing constants and an index-width helper.
package subtree_arb_pkg;

    localparam int N_REQ_DEFAULT    = 10;
    localparam int HOLD_MAX_DEFAULT = 64;

    // IDLE: arbitrating, OWN: resource granted, GAP: one dead cycle after a tenure
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    // Width of a binary requester index (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subtree_rr_arbiter_if.sv
// Request/grant bundle between the child requesters (master side drives req)
// and the arbiter (slave side drives the grant outputs).
interface subtree_rr_arbiter_if
    import subtree_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) ();

    localparam int IDW = idx_width(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );

endinterface

// File: rtl/subtree_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// above ptr, wrapping from N_REQ-1 back to 0.
module subtree_rr_pick
    import subtree_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDW   = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             valid,
    output logic [IDW-1:0]   index
);

    localparam logic [IDW:0] N_EXT = (IDW+1)'(N_REQ);

    // rot_req[k] is the request of the requester k places after ptr
    logic [N_REQ-1:0] rot_req;
    logic [IDW-1:0]   slot_idx [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slot
            logic [IDW:0] sum;
            // ptr < N_REQ, so one conditional subtraction performs the wrap
            assign sum           = {1'b0, ptr} + (IDW+1)'(gi);
            assign slot_idx[gi]  = (sum >= N_EXT) ? IDW'(sum - N_EXT) : sum[IDW-1:0];
            assign rot_req[gi]   = req[slot_idx[gi]];
        end
    endgenerate

    // Priority encode the rotated vector; the nearest slot to ptr wins
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                valid = 1'b1;
                index = slot_idx[i];
            end
        end
    end

endmodule

// File: rtl/subtree_rr_arbiter.sv
// Round-robin arbiter granting one shared resource to one of N_REQ child
// requesters. Tenure lasts while the owner holds its request; every tenure
// is followed by one GAP cycle. Optional forced revocation after HOLD_MAX
// cycles is built when macro SUBTREE_ARB_TIMEOUT_EN is defined; otherwise
// tenure is unbounded and timeout is tied low.
module subtree_rr_arbiter
    import subtree_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEFAULT,
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    subtree_rr_arbiter_if.slave bus
);

    localparam int             IDW  = idx_width(N_REQ);
    localparam logic [IDW-1:0] LAST = IDW'(N_REQ - 1);

    generate
        if (N_REQ < 2 || N_REQ > 16 || HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_bad_params
            $error("subtree_rr_arbiter: N_REQ must be 2..16 and HOLD_MAX 1..65535");
        end
    endgenerate

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q,   ptr_d;
    logic [IDW-1:0] owner_q, owner_d;

    logic           pick_valid;
    logic [IDW-1:0] pick_idx;

`ifdef SUBTREE_ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);
    logic [15:0] hold_q,    hold_d;
    logic        timeout_q, timeout_d;
`endif

    subtree_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // Next-state logic: arbitrate in IDLE, watch the owner in OWN, idle one cycle in GAP
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
`ifdef SUBTREE_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
`ifdef SUBTREE_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            OWN: begin
                // A voluntary release wins over a simultaneous timeout
                if (!bus.req[owner_q]) begin
                    state_d = GAP;
                end
`ifdef SUBTREE_ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    state_d   = GAP;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
`endif
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
`ifdef SUBTREE_ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
`ifdef SUBTREE_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Outputs decode directly from registered state, so they are glitch-free
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign bus.gnt[gi] = (state_q == OWN) && (owner_q == IDW'(gi));
        end
    endgenerate

    assign bus.busy   = (state_q == OWN);
    assign bus.gnt_id = (state_q == OWN) ? owner_q : '0;

`ifdef SUBTREE_ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_subtree_rr_arbiter.sv
// Self-checking bench for subtree_rr_arbiter: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// behavioural model. Timeout expectations follow SUBTREE_ARB_TIMEOUT_EN.
module tb_subtree_rr_arbiter;
    import subtree_arb_pkg::*;

    localparam int N    = 10;
    localparam int HOLD = 64;
    localparam int IDW  = $clog2(N);
`ifdef SUBTREE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subtree_rr_arbiter_if #(.N_REQ(N)) bus ();

    subtree_rr_arbiter #(
        .N_REQ    (N),
        .HOLD_MAX (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: owner index (-1 = none), a cool-down flag for the
    // dead cycle after a tenure, the rotating start point and tenure length.
    int m_owner = -1;
    bit m_cool  = 1'b0;
    int m_ptr   = 0;
    int m_owned = 0;
    bit m_pulse = 1'b0;

    task automatic model_edge(input bit r_rst, input logic [N-1:0] r);
        bit found;
        m_pulse = 1'b0;
        if (r_rst) begin
            m_owner = -1; m_cool = 1'b0; m_ptr = 0; m_owned = 0;
        end else if (m_owner >= 0) begin
            m_owned++;
            if (!r[m_owner]) begin
                m_owner = -1; m_cool = 1'b1;
            end else if (TO_EN && m_owned >= HOLD) begin
                m_owner = -1; m_cool = 1'b1; m_pulse = 1'b1;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!found && r[i]) begin
                    found = 1'b1; m_owner = i; m_ptr = (i + 1) % N; m_owned = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, bus.req);
        #1;
    endtask

    typedef struct {
        bit             rst;
        logic [N-1:0]   req;
        logic [N-1:0]   gnt;
        int             id;
        bit             busy;
    } vec_t;

    function automatic vec_t mk(input bit r, input logic [N-1:0] q, input logic [N-1:0] g,
                                input int id, input bit b);
        vec_t v;
        v.rst = r; v.req = q; v.gnt = g; v.id = id; v.busy = b;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] prev_gnt;
        logic [N-1:0] exp_gnt;
        bit           prev_busy;
        int           wait_cnt [N];
        int           max_wait;
        int           to_cnt, to_at, busy_lost, drop_thr;

        // Directed vectors, one clock edge per row
        tbl[0]  = mk(1'b1, 10'h3FF, 10'h000, 0, 1'b0);
        tbl[1]  = mk(1'b0, 10'h024, 10'h004, 2, 1'b1);
        tbl[2]  = mk(1'b0, 10'h024, 10'h004, 2, 1'b1);
        tbl[3]  = mk(1'b0, 10'h020, 10'h000, 0, 1'b0);
        tbl[4]  = mk(1'b0, 10'h020, 10'h000, 0, 1'b0);
        tbl[5]  = mk(1'b0, 10'h020, 10'h020, 5, 1'b1);
        tbl[6]  = mk(1'b0, 10'h000, 10'h000, 0, 1'b0);
        tbl[7]  = mk(1'b0, 10'h3FF, 10'h000, 0, 1'b0);
        tbl[8]  = mk(1'b0, 10'h3FF, 10'h040, 6, 1'b1);
        tbl[9]  = mk(1'b0, 10'h3FF, 10'h040, 6, 1'b1);
        tbl[10] = mk(1'b1, 10'h3FF, 10'h000, 0, 1'b0);
        tbl[11] = mk(1'b0, 10'h3FF, 10'h001, 0, 1'b1);
        tbl[12] = mk(1'b0, 10'h000, 10'h000, 0, 1'b0);
        tbl[13] = mk(1'b0, 10'h201, 10'h000, 0, 1'b0);
        tbl[14] = mk(1'b0, 10'h201, 10'h200, 9, 1'b1);
        tbl[15] = mk(1'b0, 10'h001, 10'h000, 0, 1'b0);
        tbl[16] = mk(1'b0, 10'h001, 10'h000, 0, 1'b0);
        tbl[17] = mk(1'b0, 10'h001, 10'h001, 0, 1'b1);

        rst = 1'b1;
        bus.req = '0;
        step();
        step();
        chk("reset_gnt", 32'(bus.gnt), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_timeout", 32'(bus.timeout), 32'h0);

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst;
            bus.req = tbl[i].req;
            step();
            chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d_id", i), 32'(bus.gnt_id), 32'(tbl[i].id));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_timeout", i), 32'(bus.timeout), 32'h0);
        end

        // All requesters high: owners release one cycle each, order must be 0..9,0
        rst = 1'b1; bus.req = '0; step();
        rst = 1'b0; bus.req = '1;
        for (int k = 0; k <= N; k++) begin
            for (int w = 0; w < 20 && !bus.busy; w++) step();
            chk($sformatf("rr_order%0d_busy", k), 32'(bus.busy), 32'h1);
            chk($sformatf("rr_order%0d_id", k), 32'(bus.gnt_id), 32'(k % N));
            if (bus.busy) begin
                bus.req = ~(N'(1) << bus.gnt_id);
                step();
                bus.req = '1;
            end
        end

        // Owner holds its request for 100 cycles
        rst = 1'b1; bus.req = '0; step();
        rst = 1'b0; bus.req = N'(1) << 3; step();
        chk("hold_grant", 32'(bus.gnt), 32'h8);
        to_cnt = 0; to_at = -1; busy_lost = 0;
        for (int c = 1; c < 100; c++) begin
            step();
            if (!bus.busy) busy_lost++;
            if (bus.timeout) begin
                to_cnt++;
                to_at = c;
                chk("hold_timeout_gnt", 32'(bus.gnt), 32'h0);
            end
        end
`ifdef SUBTREE_ARB_TIMEOUT_EN
        chk("hold_timeout_count", 32'(to_cnt), 32'd1);
        chk("hold_timeout_cycle", 32'(to_at), 32'(HOLD));
        chk("hold_idle_cycles", 32'(busy_lost), 32'd2);
`else
        chk("hold_timeout_count", 32'(to_cnt), 32'd0);
        chk("hold_idle_cycles", 32'(busy_lost), 32'd0);
`endif

        // Reset in the middle of a tenure owned by index 7
        rst = 1'b1; bus.req = '0; step();
        rst = 1'b0; bus.req = N'(1) << 7; step();
        chk("mid_rst_pre_id", 32'(bus.gnt_id), 32'd7);
        step();
        chk("mid_rst_pre_id2", 32'(bus.gnt_id), 32'd7);
        rst = 1'b1; bus.req = '1; step();
        chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        chk("mid_rst_id", 32'(bus.gnt_id), 32'h0);
        chk("mid_rst_timeout", 32'(bus.timeout), 32'h0);
        rst = 1'b0; step();
        chk("mid_rst_next_gnt", 32'(bus.gnt), 32'h1);

        // Randomized run against the model plus structural invariants
        rst = 1'b1; bus.req = '0; step();
        prev_gnt = '0; prev_busy = 1'b0; max_wait = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            drop_thr = ((cyc / 1000) % 2 == 1) ? 1 : 8;
            r = bus.req;
            for (int i = 0; i < N; i++) begin
                if (bus.busy && int'(bus.gnt_id) == i) begin
                    if ($urandom_range(63, 0) < drop_thr) r[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    r[i] = ~r[i];
                end
            end
            rst = ($urandom_range(499, 0) == 0);
            bus.req = r;
            step();

            exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            chk("rand_gnt", 32'(bus.gnt), 32'(exp_gnt));
            chk("rand_id", 32'(bus.gnt_id), 32'((m_owner >= 0) ? m_owner : 0));
            chk("rand_busy", 32'(bus.busy), 32'(m_owner >= 0));
            chk("rand_timeout", 32'(bus.timeout), 32'(m_pulse));
            chk("rand_onehot", 32'($onehot0(bus.gnt)), 32'h1);
            chk("rand_owner_change_gap",
                32'(prev_gnt != '0 && bus.gnt != '0 && bus.gnt != prev_gnt), 32'h0);

            for (int i = 0; i < N; i++) if (!r[i] || rst) wait_cnt[i] = 0;
            if (bus.busy && !prev_busy) begin
                for (int i = 0; i < N; i++) begin
                    if (i == int'(bus.gnt_id)) wait_cnt[i] = 0;
                    else if (r[i]) wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
            prev_gnt = bus.gnt;
            prev_busy = bus.busy;
        end
        chk("rand_starve_bound", 32'(max_wait <= N), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/subtree_rr_arbiter.md
SUBTREE_RR_ARBITER -- requirements
Module: subtree_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 10, SHALL set the number of requesters (child instances sharing one resource); legal range 2..16.
REQ-002 Parameter HOLD_MAX, default 64, SHALL set the maximum grant tenure in cycles; legal range 1..65535.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port req  input  N_REQ  SHALL carry per-requester request levels; each owner holds its bit high for the whole tenure.
REQ-006 Port gnt  output  N_REQ  SHALL be the one-hot grant vector, or all zeros.
REQ-007 Port gnt_id  output  $clog2(N_REQ)  SHALL be the binary index of the current owner; 0 when no grant.
REQ-008 Port busy  output  1  SHALL be high whenever the resource is owned.
REQ-009 Port timeout  output  1  SHALL be a one-cycle pulse on forced revocation.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, OWN and GAP.
REQ-011 In IDLE with req != 0 at edge t, the block SHALL enter OWN and assert gnt, gnt_id and busy from cycle t+1 (latency 1).
REQ-012 Selection SHALL be round-robin: first set req bit at or above pointer ptr, wrapping from N_REQ-1 to 0.
REQ-013 On each grant, ptr SHALL load (winner+1) mod N_REQ.
REQ-014 In OWN, the block SHALL leave to GAP when req[gnt_id] drops; gnt/busy deassert in the same cycle GAP is entered.
REQ-015 GAP SHALL last exactly one cycle with gnt=0, then return to IDLE; back-to-back grants are therefore at least 2 cycles apart.
REQ-016 Requests from non-owners during OWN or GAP SHALL be ignored, not queued.
REQ-017 A requester dropping req before being granted SHALL lose nothing; selection uses req at the sampling edge only.
REQ-018 With all N_REQ bits held high continuously, grants SHALL visit indices 0,1,...,N_REQ-1,0 in order.
REQ-019 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-020 While rst is high, the block SHALL force state=IDLE, ptr=0, gnt=0, gnt_id=0, busy=0, timeout=0 and hold-counter=0, regardless of req.
REQ-021 Reset asserted during OWN SHALL drop gnt on the next edge; no GAP cycle and no timeout pulse are produced.
REQ-022 The first arbitration after reset release SHALL be sampled on the first edge with rst low.

Configuration
REQ-023 Macro SUBTREE_ARB_TIMEOUT_EN, when defined, SHALL include a hold counter that clears on grant and increments each OWN cycle.
REQ-024 With SUBTREE_ARB_TIMEOUT_EN defined and the counter reaching HOLD_MAX-1 in OWN, the block SHALL revoke the grant, pulse timeout for one cycle and enter GAP; release and timeout in the same cycle count as a normal release (no pulse).
REQ-025 Without SUBTREE_ARB_TIMEOUT_EN, the counter SHALL not exist, timeout SHALL be tied 0 and tenure SHALL be unbounded.

Structure
REQ-026 Package subtree_arb_pkg SHALL hold the state enum (IDLE, OWN, GAP) and the default N_REQ/HOLD_MAX constants.
REQ-027 Round-robin selection SHALL live in one combinational sub-module, subtree_rr_pick (inputs req and ptr; outputs valid and index).

Verification
REQ-028 req=10'b00_0010_0100 from IDLE after reset -> gnt=bit 2 at t+1, gnt_id=2, ptr=3; drop req[2] -> GAP, then gnt=bit 5 two cycles later.
REQ-029 req=all ones held for 30 cycles -> grant order 0..9 then 0, each tenure ended by its owner dropping and re-raising req.
REQ-030 Owner holds req 100 cycles, HOLD_MAX=64, macro defined -> timeout pulses once at grant+64 and gnt=0; macro undefined -> grant persists 100 cycles, timeout stays 0.
REQ-031 rst pulsed mid-OWN with gnt_id=7 -> gnt=0 next edge, ptr=0; with req=all ones, next grant is index 0.
REQ-032 Random req stimulus for 10k cycles -> assertions hold: gnt one-hot or zero; no owner changes without a GAP cycle; every continuously-asserted request is granted within N_REQ tenures.
